// File: rtl/camera_pkg.sv
// Shared types for the camera pixel packer: packed output word, FSM states, coordinate width.
package camera_pkg;

    localparam int CAM_COORD_W         = 16;
    localparam int CAM_PIX_W           = 8;
    localparam int CAM_PIXELS_PER_WORD = 4;
    localparam int CAM_DATA_W          = CAM_PIX_W * CAM_PIXELS_PER_WORD;

    typedef struct packed {
        logic [CAM_DATA_W-1:0] data;
        logic                  sof;
        logic                  eol;
        logic                  eof;
    } cam_word_t;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        ACTIVE = 2'd1,
        DROP   = 2'd2
    } packer_state_e;

endpackage

// File: rtl/pix_word_fifo.sv
// Synchronous FIFO of packed camera words; the head entry is presented straight from storage flops.
module pix_word_fifo
    import camera_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic      clk_i,
    input  logic      reset_ni,
    input  logic      push_i,
    input  cam_word_t push_word_i,
    input  logic      pop_i,
    output cam_word_t pop_word_o,
    output logic      valid_o,
    output logic      full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    cam_word_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign valid_o    = (count_q != '0);
    assign full_o     = (count_q == FULL_CNT);
    assign do_pop     = pop_i & valid_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push    = push_i & (~full_o | do_pop);
    assign pop_word_o = valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_word_i;
    end

endmodule

// File: rtl/camera_pixel_packer.sv
// Packs a raster-ordered tagged pixel stream into SOF/EOL/EOF-tagged words, checks order and buffers words.
module camera_pixel_packer
    import camera_pkg::*;
#(
    parameter int PIX_WIDTH       = CAM_PIX_W,
    parameter int PIXELS_PER_WORD = CAM_PIXELS_PER_WORD,
    parameter int FRAME_WIDTH     = 512,
    parameter int FRAME_HEIGHT    = 400,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                                 clk_i,
    input  logic                                 reset_ni,
    input  logic                                 pix_valid_i,
    input  logic [PIX_WIDTH-1:0]                 pix_i,
    input  logic [CAM_COORD_W-1:0]               row_i,
    input  logic [CAM_COORD_W-1:0]               col_i,
    input  logic                                 clear_i,
    output logic                                 word_valid_o,
    input  logic                                 word_ready_i,
    output logic [PIX_WIDTH*PIXELS_PER_WORD-1:0] word_data_o,
    output logic                                 word_sof_o,
    output logic                                 word_eol_o,
    output logic                                 word_eof_o,
    output logic                                 overflow_o,
    output logic                                 seq_error_o,
    output logic [15:0]                          frame_count_o,
    output packer_state_e                        dbg_state_o
);

    localparam int DATA_W = PIX_WIDTH * PIXELS_PER_WORD;
    localparam int LANE_W = $clog2(PIXELS_PER_WORD);
    localparam logic [CAM_COORD_W-1:0] LAST_COL  = CAM_COORD_W'(FRAME_WIDTH - 1);
    localparam logic [CAM_COORD_W-1:0] LAST_ROW  = CAM_COORD_W'(FRAME_HEIGHT - 1);
    localparam logic [LANE_W-1:0]      LAST_LANE = LANE_W'(PIXELS_PER_WORD - 1);

    packer_state_e          state_q, state_d, eff_state;
    logic [CAM_COORD_W-1:0] exp_row_q, exp_row_d, exp_col_q, exp_col_d;
    logic [DATA_W-1:0]      acc_q, acc_d, acc_merged;
    logic                   sof_pend_q, sof_pend_d, word_sof;
    logic                   wr_en_q, wr_en_d;
    cam_word_t              wr_word_q, wr_word_d, fifo_word;
    logic                   overflow_q, seq_error_q;
    logic [15:0]            frame_count_q;
    logic                   fifo_full, fifo_valid, fifo_pop, wr_lost, wr_ok;
    logic                   is_origin, at_expected, word_done, take, restart, seq_err;
    logic [LANE_W-1:0]      lane;

    // Output stream: a word transfers on a cycle where word_valid_o and word_ready_i are both high;
    // while valid is high and ready low, data and tags stay unchanged.
    assign fifo_pop    = fifo_valid & word_ready_i;
    assign wr_lost     = wr_en_q & fifo_full & ~fifo_pop;
    assign wr_ok       = wr_en_q & ~wr_lost;
    assign lane        = col_i[LANE_W-1:0];
    assign is_origin   = pix_valid_i && (row_i == '0) && (col_i == '0);
    assign at_expected = (row_i == exp_row_q) && (col_i == exp_col_q);
    assign word_done   = (lane == LAST_LANE) || (col_i == LAST_COL);

    // A word lost this cycle forces DROP semantics onto the pixel arriving in the same cycle.
    always_comb begin
        eff_state = wr_lost ? DROP : state_q;
        state_d   = eff_state;
        take      = 1'b0;
        restart   = 1'b0;
        seq_err   = 1'b0;
        unique case (eff_state)
            SYNC, DROP: begin
                if (is_origin) begin
                    take    = 1'b1;
                    restart = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (pix_valid_i) begin
                    if (at_expected) begin
                        take = 1'b1;
                    end else begin
                        seq_err = 1'b1;
                        take    = is_origin;
                        restart = is_origin;
                        state_d = is_origin ? ACTIVE : SYNC;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        acc_merged = restart ? '0 : acc_q;
        acc_merged[int'(lane)*PIX_WIDTH +: PIX_WIDTH] = pix_i;
        word_sof   = (sof_pend_q & ~restart) | is_origin;
        acc_d      = acc_q;
        sof_pend_d = sof_pend_q;
        exp_row_d  = exp_row_q;
        exp_col_d  = exp_col_q;
        wr_en_d    = 1'b0;
        wr_word_d  = '0;
        if (wr_lost || seq_err) begin
            acc_d      = '0;
            sof_pend_d = 1'b0;
        end
        if (take) begin
            if (word_done) begin
                wr_en_d        = 1'b1;
                wr_word_d.data = acc_merged;
                wr_word_d.sof  = word_sof;
                wr_word_d.eol  = (col_i == LAST_COL);
                wr_word_d.eof  = (col_i == LAST_COL) && (row_i == LAST_ROW);
                acc_d          = '0;
                sof_pend_d     = 1'b0;
            end else begin
                acc_d      = acc_merged;
                sof_pend_d = word_sof;
            end
            if (col_i == LAST_COL) begin
                exp_col_d = '0;
                exp_row_d = (row_i == LAST_ROW) ? '0 : row_i + 1'b1;
            end else begin
                exp_col_d = col_i + 1'b1;
                exp_row_d = row_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= SYNC;
            exp_row_q     <= '0;
            exp_col_q     <= '0;
            acc_q         <= '0;
            sof_pend_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_word_q     <= '0;
            overflow_q    <= 1'b0;
            seq_error_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            exp_row_q     <= exp_row_d;
            exp_col_q     <= exp_col_d;
            acc_q         <= acc_d;
            sof_pend_q    <= sof_pend_d;
            wr_en_q       <= wr_en_d;
            wr_word_q     <= wr_word_d;
            overflow_q    <= wr_lost | (overflow_q & ~clear_i);
            seq_error_q   <= seq_err | (seq_error_q & ~clear_i);
            frame_count_q <= frame_count_q + {15'd0, wr_ok & wr_word_q.eof};
        end
    end

    pix_word_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .push_i     (wr_ok),
        .push_word_i(wr_word_q),
        .pop_i      (word_ready_i),
        .pop_word_o (fifo_word),
        .valid_o    (fifo_valid),
        .full_o     (fifo_full)
    );

    assign word_valid_o  = fifo_valid;
    assign word_data_o   = fifo_word.data;
    assign word_sof_o    = fifo_word.sof;
    assign word_eol_o    = fifo_word.eol;
    assign word_eof_o    = fifo_word.eof;
    assign overflow_o    = overflow_q;
    assign seq_error_o   = seq_error_q;
    assign frame_count_o = frame_count_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_camera_pixel_packer.sv
// Bench for camera_pixel_packer on a 10x6 frame: raster-rule model, per-cycle compare, pinned literal words.
module tb_camera_pixel_packer;

    localparam int FW    = 10;
    localparam int FH    = 6;
    localparam int DEPTH = 16;
    localparam int HUNT = 0, LOCKED = 1, DROPPING = 2;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        pix_valid_i = 1'b0;
    logic [7:0]  pix_i = '0;
    logic [15:0] row_i = '0, col_i = '0;
    logic        clear_i = 1'b0;
    logic        word_ready_i = 1'b1;
    logic        word_valid_o, word_sof_o, word_eol_o, word_eof_o, overflow_o, seq_error_o;
    logic [31:0] word_data_o;
    logic [15:0] frame_count_o;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int ready_pct = 100;

    // Words are {sof, eol, eof, data}.
    logic [34:0] exp_q[$];
    logic [34:0] dut_log[$];
    logic [34:0] mdl_log[$];

    int          m_mode = HUNT;
    int          m_er = 0, m_ec = 0;
    logic [31:0] m_part = '0;
    bit          m_part_sof = 0;
    bit          m_pend_v = 0, m_nv = 0;
    logic [34:0] m_pend = '0, m_nw = '0;
    bit          m_ovf = 0, m_seq = 0;
    logic [15:0] m_fc = '0;

    camera_pixel_packer #(
        .FRAME_WIDTH (FW),
        .FRAME_HEIGHT(FH),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i        (clk),
        .reset_ni     (reset_ni),
        .pix_valid_i  (pix_valid_i),
        .pix_i        (pix_i),
        .row_i        (row_i),
        .col_i        (col_i),
        .clear_i      (clear_i),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i),
        .word_data_o  (word_data_o),
        .word_sof_o   (word_sof_o),
        .word_eol_o   (word_eol_o),
        .word_eof_o   (word_eof_o),
        .overflow_o   (overflow_o),
        .seq_error_o  (seq_error_o),
        .frame_count_o(frame_count_o),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- model: raster rules on a word queue ----------------
    task automatic m_take(input int r, input int c, input logic [7:0] p);
        m_part = m_part | (32'(p) << (8 * (c % 4)));
        if (r == 0 && c == 0) m_part_sof = 1;
        if ((c % 4 == 3) || (c == FW - 1)) begin
            m_nv = 1;
            m_nw = {m_part_sof, c == FW - 1, (c == FW - 1) && (r == FH - 1), m_part};
            m_part = '0;
            m_part_sof = 0;
        end
        if (c == FW - 1) begin
            m_ec = 0;
            m_er = (r == FH - 1) ? 0 : r + 1;
        end else begin
            m_ec = c + 1;
            m_er = r;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge reset_ni);
        if (!reset_ni) begin
            exp_q.delete();
            m_mode = HUNT; m_er = 0; m_ec = 0; m_part = '0; m_part_sof = 0;
            m_pend_v = 0; m_ovf = 0; m_seq = 0; m_fc = '0;
        end else begin
            bit rd, lost, origin, err;
            int r, c;
            if (word_valid_o && word_ready_i)
                dut_log.push_back({word_sof_o, word_eol_o, word_eof_o, word_data_o});
            r = int'(row_i);
            c = int'(col_i);
            rd     = (exp_q.size() > 0) && word_ready_i;
            lost   = m_pend_v && (exp_q.size() == DEPTH) && !rd;
            origin = pix_valid_i && r == 0 && c == 0;
            err    = 0;
            m_nv   = 0;
            if (lost) begin
                m_mode = DROPPING; m_part = '0; m_part_sof = 0;
            end
            if (pix_valid_i) begin
                if (m_mode == LOCKED) begin
                    if (r == m_er && c == m_ec) begin
                        m_take(r, c, pix_i);
                    end else begin
                        err = 1; m_part = '0; m_part_sof = 0;
                        if (origin) m_take(r, c, pix_i);
                        else m_mode = HUNT;
                    end
                end else if (origin) begin
                    m_part = '0; m_part_sof = 0; m_mode = LOCKED;
                    m_take(r, c, pix_i);
                end
            end
            if (rd) begin
                mdl_log.push_back(exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (m_pend_v && !lost) begin
                exp_q.push_back(m_pend);
                if (m_pend[32]) m_fc = m_fc + 16'd1;
            end
            m_pend_v = m_nv;
            m_pend   = m_nw;
            if (clear_i) begin m_ovf = 0; m_seq = 0; end
            if (lost) m_ovf = 1;
            if (err)  m_seq = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        bit          exp_v;
        logic [34:0] exp_w, act_w;
        @(negedge clk);
        exp_v = exp_q.size() > 0;
        exp_w = exp_v ? exp_q[0] : '0;
        act_w = {word_sof_o, word_eol_o, word_eof_o, word_data_o};
        checks++;
        if (word_valid_o !== exp_v || (exp_v && act_w !== exp_w) || overflow_o !== m_ovf ||
            seq_error_o !== m_seq || frame_count_o !== m_fc) begin
            errors++;
            if (errors < 20)
                $display("FAIL cycle_cmp t=%0t valid %b want %b word %h want %h ovf %b want %b seq %b want %b fc %0d want %0d",
                         $time, word_valid_o, exp_v, act_w, exp_w, overflow_o, m_ovf,
                         seq_error_o, m_seq, frame_count_o, m_fc);
        end
    end

    // ---------------- ready driver ----------------
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       word_ready_i = 1'b1;
            1:       word_ready_i = 1'b0;
            default: word_ready_i = ($urandom_range(0, 99) < ready_pct);
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_pix(input int r, input int c);
        pix_valid_i = 1'b1;
        row_i = 16'(r);
        col_i = 16'(c);
        pix_i = 8'(c + 16 * r);
        tick();
        pix_valid_i = 1'b0;
    endtask

    task automatic send_frame(input int skip_r, input int skip_c, input int gap);
        for (int r = 0; r < FH; r++)
            for (int c = 0; c < FW; c++)
                if (!(r == skip_r && c == skip_c)) begin
                    send_pix(r, c);
                    idle(gap);
                end
    endtask

    function automatic logic [34:0] mkw(input bit sof, input bit eol, input bit eof, input logic [31:0] d);
        return {sof, eol, eof, d};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input int idx, input logic [34:0] exp);
        chk(name, (idx < dut_log.size()) ? 64'(dut_log[idx]) : '1, 64'(exp));
        chk({name, "_model"}, (idx < mdl_log.size()) ? 64'(mdl_log[idx]) : '1, 64'(exp));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base;
        reset_ni = 1'b0;
        idle(3);
        chk("reset_valid", 64'(word_valid_o), 0);
        chk("reset_fc", 64'(frame_count_o), 0);
        chk("reset_flags", 64'({overflow_o, seq_error_o}), 0);
        reset_ni = 1'b1;
        idle(2);

        // full frame, ready held high
        base = dut_log.size();
        send_frame(-1, -1, 0);
        idle(6);
        chk("t1_words", 64'(dut_log.size() - base), 18);
        chk_word("t1_w0", base + 0, mkw(1, 0, 0, 32'h03020100));
        chk_word("t1_w1", base + 1, mkw(0, 0, 0, 32'h07060504));
        chk_word("t1_w2_partial", base + 2, mkw(0, 1, 0, 32'h00000908));
        chk_word("t1_w3", base + 3, mkw(0, 0, 0, 32'h13121110));
        chk_word("t1_last", base + 17, mkw(0, 1, 1, 32'h00005958));
        chk("t1_fc", 64'(frame_count_o), 1);

        // same frame with idle cycles between pixels
        send_frame(-1, -1, 1);
        idle(6);
        chk("t2_fc", 64'(frame_count_o), 2);

        // skipped pixel mid-frame, then an intact frame
        base = dut_log.size();
        send_frame(2, 5, 0);
        idle(6);
        chk("t3_words", 64'(dut_log.size() - base), 7);
        chk("t3_seq", 64'(seq_error_o), 1);
        chk("t3_fc", 64'(frame_count_o), 2);
        send_frame(-1, -1, 0);
        idle(6);
        chk("t3_fc_next", 64'(frame_count_o), 3);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        tick();
        chk("t3_seq_cleared", 64'(seq_error_o), 0);

        // unexpected (0,0) restarts the frame; clear in that same cycle loses to the error
        send_pix(0, 0);
        send_pix(0, 1);
        base = dut_log.size();
        clear_i = 1'b1;
        send_pix(0, 0);
        clear_i = 1'b0;
        for (int r = 0; r < FH; r++)
            for (int c = 0; c < FW; c++)
                if (r != 0 || c != 0) send_pix(r, c);
        idle(6);
        chk("t3b_seq_kept", 64'(seq_error_o), 1);
        chk("t3b_fc", 64'(frame_count_o), 4);
        chk_word("t3b_first", base, mkw(1, 0, 0, 32'h03020100));
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;

        // consumer stalled across a frame of 18 words
        ready_mode = 1;
        idle(2);
        base = dut_log.size();
        send_frame(-1, -1, 0);
        idle(6);
        chk("t4_ovf", 64'(overflow_o), 1);
        chk("t4_fc_held", 64'(frame_count_o), 4);
        chk("t4_valid", 64'(word_valid_o), 1);
        ready_mode = 0;
        idle(25);
        chk("t4_drained", 64'(dut_log.size() - base), 16);
        chk_word("t4_first", base, mkw(1, 0, 0, 32'h03020100));
        chk_word("t4_last_kept", base + 15, mkw(0, 0, 0, 32'h53525150));
        send_frame(-1, -1, 0);
        idle(6);
        chk("t4_fc_next", 64'(frame_count_o), 5);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        tick();
        chk("t4_ovf_cleared", 64'(overflow_o), 0);

        // reset mid-row with words queued and a flag raised
        ready_mode = 1;
        for (int c = 0; c < FW; c++) send_pix(0, c);
        send_pix(1, 0);
        send_pix(1, 1);
        send_pix(1, 3);
        idle(2);
        #2 reset_ni = 1'b0;
        #1;
        chk("t5_valid", 64'(word_valid_o), 0);
        chk("t5_data", 64'({word_sof_o, word_eol_o, word_eof_o, word_data_o}), 0);
        chk("t5_flags", 64'({overflow_o, seq_error_o}), 0);
        chk("t5_fc", 64'(frame_count_o), 0);
        tick();
        reset_ni = 1'b1;
        ready_mode = 0;
        tick();
        send_pix(1, 4);
        send_pix(1, 5);
        idle(4);
        chk("t5_ignored", 64'(word_valid_o), 0);
        base = dut_log.size();
        send_frame(-1, -1, 0);
        idle(6);
        chk_word("t5_first_sof", base, mkw(1, 0, 0, 32'h03020100));
        chk("t5_fc_after", 64'(frame_count_o), 1);

        // random ready at 60% over three back-to-back frames
        ready_pct = 60;
        ready_mode = 2;
        base = dut_log.size();
        repeat (3) send_frame(-1, -1, 0);
        ready_mode = 0;
        idle(30);
        chk("t6_words", 64'(dut_log.size() - base), 54);
        chk("t6_fc", 64'(frame_count_o), 4);
        chk("t6_flags", 64'({overflow_o, seq_error_o}), 0);

        // sparse ready: FIFO fills, overflow and full-with-read cycles against the model
        ready_pct = 20;
        ready_mode = 2;
        repeat (2) send_frame(-1, -1, 0);
        ready_mode = 0;
        idle(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
